// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer: execution modes,
// the physical fetch address layout and the per-mode region bases.
package fetch_sequencer_pkg;

    localparam int PC_W   = 4;
    localparam int MODE_W = 2;
    localparam int ADDR_W = MODE_W + PC_W;

    typedef enum logic [MODE_W-1:0] {
        MODE_NORMAL = 2'b00,
        MODE_SWI    = 2'b01,
        MODE_EXC    = 2'b10,
        MODE_HWI    = 2'b11
    } mode_t;

    typedef struct packed {
        mode_t           mode;
        logic [PC_W-1:0] pc;
    } addr_fields_t;

    // Same six bits seen either as a flat physical address or as mode/pc.
    typedef union packed {
        logic [ADDR_W-1:0] phys_addr;
        addr_fields_t      f;
    } addr_t;

    localparam logic [ADDR_W-1:0] REGION_BASE_NORMAL = 6'h00;
    localparam logic [ADDR_W-1:0] REGION_BASE_SWI    = 6'h10;
    localparam logic [ADDR_W-1:0] REGION_BASE_EXC    = 6'h20;
    localparam logic [ADDR_W-1:0] REGION_BASE_HWI    = 6'h30;

    function automatic logic [ADDR_W-1:0] region_base(input mode_t m);
        logic [ADDR_W-1:0] base;
        base = REGION_BASE_NORMAL;
        case (m)
            MODE_NORMAL: base = REGION_BASE_NORMAL;
            MODE_SWI:    base = REGION_BASE_SWI;
            MODE_EXC:    base = REGION_BASE_EXC;
            MODE_HWI:    base = REGION_BASE_HWI;
            default:     base = REGION_BASE_NORMAL;
        endcase
        return base;
    endfunction

endpackage

// File: rtl/fetch_sequencer_next_sel.sv
// Combinational next-state selection for the fetch sequencer: resolves
// exceptions, software interrupts, interrupt return and hardware interrupts.
module fetch_sequencer_next_sel
    import fetch_sequencer_pkg::*;
(
    input  mode_t           mode,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] saved_pc,
    input  logic [PC_W-1:0] fault_pc,
    input  logic            halted,
    input  logic            hwi_pending,
    input  logic            prev_iret,
    input  logic            jump_en,
    input  logic [PC_W-1:0] jump_target,
    input  logic            swi_req,
    input  logic            exc_req,
    input  logic            iret,
    output mode_t           next_mode,
    output logic [PC_W-1:0] next_pc,
    output logic [PC_W-1:0] next_saved_pc,
    output logic [PC_W-1:0] next_fault_pc,
    output logic            next_halt,
    output logic            hwi_take,
    output logic            iret_take
);

    logic [PC_W-1:0] seq_next;
    logic [PC_W-1:0] pc_inc;
    logic            in_normal;

    assign pc_inc    = pc + PC_W'(1);
    assign seq_next  = jump_en ? jump_target : pc_inc;
    assign in_normal = (mode == MODE_NORMAL);

    always_comb begin
        next_mode     = mode;
        next_pc       = pc;
        next_saved_pc = saved_pc;
        next_fault_pc = fault_pc;
        next_halt     = halted;
        hwi_take      = 1'b0;
        iret_take     = 1'b0;

        if (!halted) begin
            if (exc_req) begin
                next_fault_pc = pc;
                if (in_normal) begin
                    next_mode     = MODE_EXC;
                    next_pc       = '0;
                    next_saved_pc = pc_inc;
                end else begin
                    next_halt = 1'b1;
                end
            end else if (swi_req) begin
                if (in_normal) begin
                    next_mode     = MODE_SWI;
                    next_pc       = '0;
                    next_saved_pc = seq_next;
                end else begin
                    next_halt = 1'b1;
                end
            end else if (iret) begin
                // A return with nothing to return from is an illegal instruction.
                if (in_normal) begin
                    next_mode     = MODE_EXC;
                    next_pc       = '0;
                    next_saved_pc = pc_inc;
                    next_fault_pc = pc;
                end else begin
                    next_mode = MODE_NORMAL;
                    next_pc   = saved_pc;
                    iret_take = 1'b1;
                end
            end else if (hwi_pending && in_normal && !prev_iret) begin
                next_mode     = MODE_HWI;
                next_pc       = '0;
                next_saved_pc = seq_next;
                hwi_take      = 1'b1;
            end else begin
                next_pc = seq_next;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer top: holds pc, mode, return/fault registers and the
// single-entry hardware interrupt latch; drives the registered fetch address.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            jump_en,
    input  logic [PC_W-1:0] jump_target,
    input  logic            swi_req,
    input  logic            exc_req,
    input  logic            iret,
    input  logic            hwi_req,
    output addr_t           addr,
    output mode_t           mode,
    output logic            halted,
    output logic [PC_W-1:0] fault_pc
);

    mode_t           mode_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] saved_pc_q;
    logic [PC_W-1:0] fault_pc_q;
    logic            halted_q;
    logic            hwi_pending_q;
    logic            prev_iret_q;

    mode_t           next_mode;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] next_saved_pc;
    logic [PC_W-1:0] next_fault_pc;
    logic            next_halt;
    logic            hwi_take;
    logic            iret_take;
    logic            next_pending;

    fetch_sequencer_next_sel u_next_sel (
        .mode          (mode_q),
        .pc            (pc_q),
        .saved_pc      (saved_pc_q),
        .fault_pc      (fault_pc_q),
        .halted        (halted_q),
        .hwi_pending   (hwi_pending_q),
        .prev_iret     (prev_iret_q),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .swi_req       (swi_req),
        .exc_req       (exc_req),
        .iret          (iret),
        .next_mode     (next_mode),
        .next_pc       (next_pc),
        .next_saved_pc (next_saved_pc),
        .next_fault_pc (next_fault_pc),
        .next_halt     (next_halt),
        .hwi_take      (hwi_take),
        .iret_take     (iret_take)
    );

    // A request arriving in the cycle its predecessor is taken is dropped.
    always_comb begin
        next_pending = hwi_pending_q;
        if (!halted_q) begin
            if (hwi_take) begin
                next_pending = 1'b0;
            end else begin
                next_pending = hwi_pending_q | hwi_req;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q        <= MODE_NORMAL;
            pc_q          <= '0;
            saved_pc_q    <= '0;
            fault_pc_q    <= '0;
            halted_q      <= 1'b0;
            hwi_pending_q <= 1'b0;
            prev_iret_q   <= 1'b0;
        end else if (!halted_q) begin
            mode_q        <= next_mode;
            pc_q          <= next_pc;
            saved_pc_q    <= next_saved_pc;
            fault_pc_q    <= next_fault_pc;
            halted_q      <= next_halt;
            hwi_pending_q <= next_pending;
            prev_iret_q   <= iret_take;
        end
    end

    assign addr.phys_addr = region_base(mode_q) | {{MODE_W{1'b0}}, pc_q};
    assign mode           = mode_q;
    assign halted         = halted_q;
    assign fault_pc       = fault_pc_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream neighbour of the instruction memory; owns the program counter and the 2-bit execution mode.
- Drives addr_t, with phys_addr = {mode, pc}, one 16-entry region per mode.
- Handles jumps, software interrupts, exceptions, hardware interrupts and interrupt return. All redirection happens at instruction boundaries; one instruction completes per clock.

Parameters:
- PC_W, 4, program counter width (entries per region = 2**PC_W).
- MODE_W, 2, mode field width; phys_addr width = MODE_W+PC_W = 6.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- jump_en  input  1  current instruction takes a jump.
- jump_target  input  PC_W  jump destination within the current region.
- swi_req  input  1  current instruction is a software-interrupt opcode.
- exc_req  input  1  current instruction is illegal.
- iret  input  1  current instruction is return-from-interrupt.
- hwi_req  input  1  external interrupt pulse, synchronous to clk.
- addr  output  addr_t  fetch address to memory (registered).
- mode  output  mode_t  current mode.
- halted  output  1  double fault; core must stop committing.
- fault_pc  output  PC_W  pc of the last instruction that raised exc_req.

Behaviour:
- Reset values:
  - Asynchronous: pc=0, mode=NORMAL(00), saved_pc=0, hwi_pending=0, halted=0, fault_pc=0.
  - Hence addr.phys_addr=6'h00.
- Modes: NORMAL=00, SWI=01, EXC=10, HWI=11. HALT is the extra state (halted=1); mode holds its last value in HALT.
- Every rising edge, unless halted, the next {mode, pc} is selected in this priority order:
  1. exc_req:
     - In NORMAL: mode<=EXC, pc<=0, saved_pc<=pc+1, fault_pc<=pc. jump_en is ignored.
     - In any handler mode: enter HALT, fault_pc<=pc.
  2. swi_req:
     - In NORMAL: mode<=SWI, pc<=0, saved_pc<=seq_next.
     - In a handler mode: enter HALT.
  3. iret:
     - In a handler mode: mode<=NORMAL, pc<=saved_pc.
     - In NORMAL: treated as exc_req.
     - jump_en is ignored.
  4. hwi_pending taken:
     - Only taken in NORMAL, and only if the previous cycle was not an iret.
     - mode<=HWI, pc<=0, saved_pc<=seq_next, pending cleared.
  5. Otherwise: pc<=seq_next, mode unchanged.
- seq_next = jump_en ? jump_target : pc+1. Arithmetic is modulo 2**PC_W, so pc wraps 15->0 inside the same region; mode never changes by wrap.
- hwi_pending:
  - Set by hwi_req in any state except HALT.
  - A set and a clear in the same cycle leave it set only if the taken interrupt was not this one; i.e. a new hwi_req while one is being taken is lost (single-entry latch).
  - A request arriving while in a handler stays pending.
  - It is taken after iret plus exactly one NORMAL instruction (forward-progress guarantee).
- swi_req and hwi_pending in the same cycle: swi is taken, hwi stays pending.
- Nesting: none; a single saved_pc register.
- HALT: addr, mode and pc frozen; all inputs ignored; only rst exits.
- Latency: addr is valid the cycle after the controlling edge; no combinational path from inputs to addr.
- Reset asserted mid-handler: returns to NORMAL pc 0 immediately; pending is lost.

Decomposition:
- Shared types package holds:
  - mode_t enum (NORMAL, SWI, EXC, HWI).
  - addr_t struct/union exposing phys_addr[5:0] plus mode/pc views.
  - PC_W/MODE_W constants.
  - Region base constants (0x00/0x10/0x20/0x30).
- One combinational sub-module, fetch_next_sel, computes next {mode, pc, saved_pc, halt} from current state and request inputs. The top holds the registers and the pending latch.

Test Plan:
- Reset, then 16 idle cycles -> phys_addr 0x00..0x0F then back to 0x00; mode stays NORMAL.
- At pc=5: swi_req -> next addr 0x10. Run 3 cycles to 0x13, then iret -> addr 0x06, mode NORMAL.
- At pc=2: jump_en=1, target 9, and swi_req together -> addr 0x10. Later iret -> addr 0x09.
- hwi_req pulse while in SWI at 0x11 -> stays in SWI. iret -> NORMAL at saved pc for one cycle, then addr 0x30.
- exc_req at pc=7 -> addr 0x20, fault_pc=7. exc_req again inside EXC -> halted=1, addr frozen over 5 cycles. rst -> addr 0x00, halted=0.
- iret in NORMAL at pc=3 -> addr 0x20, fault_pc=3. Assert rst mid-handler at 0x22 -> immediate addr 0x00, pending cleared.
